// File: rtl/div_bcd_conv.sv
// Binary-to-BCD converter for a divider's quotient/remainder pair.
// Both operands use the shift-and-add-3 (double dabble) method, one bit per cycle.
module div_bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  quotient,
    input  logic [7:0]  rem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] q_bcd,
    output logic [11:0] r_bcd,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] LAST_ITER = 4'd7;

    // Adds 3 to any BCD digit that would overflow past 9 after the next doubling.
    function automatic logic [3:0] digit_adj(input logic [3:0] dig);
        logic [3:0] res;
        res = dig;
        if (dig >= 4'd5) begin
            res = dig + 4'd3;
        end
        return res;
    endfunction

    // One double-dabble iteration on a {BCD[11:0], BIN[7:0]} register.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] adj;
        logic [19:0] res;
        adj        = sr;
        adj[19:16] = digit_adj(sr[19:16]);
        adj[15:12] = digit_adj(sr[15:12]);
        adj[11:8]  = digit_adj(sr[11:8]);
        res        = {adj[18:0], 1'b0};
        return res;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] q_sr_q, q_sr_d;
    logic [19:0] r_sr_q, r_sr_d;
    logic [11:0] q_bcd_q, q_bcd_d;
    logic [11:0] r_bcd_q, r_bcd_d;

    logic [19:0] q_step;
    logic [19:0] r_step;

    always_comb begin
        q_step = dd_step(q_sr_q);
        r_step = dd_step(r_sr_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_sr_d  = q_sr_q;
        r_sr_d  = r_sr_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    q_sr_d  = {12'd0, quotient};
                    r_sr_d  = {12'd0, rem};
                    cnt_d   = 4'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                q_sr_d = q_step;
                r_sr_d = r_step;
                cnt_d  = cnt_q + 4'd1;
                // The final shift's result goes straight to the output registers.
                if (cnt_q == LAST_ITER) begin
                    q_bcd_d = q_step[19:8];
                    r_bcd_d = r_step[19:8];
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            q_sr_q  <= 20'd0;
            r_sr_q  <= 20'd0;
            q_bcd_q <= 12'd0;
            r_bcd_q <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_sr_q  <= q_sr_d;
            r_sr_q  <= r_sr_d;
            q_bcd_q <= q_bcd_d;
            r_bcd_q <= r_bcd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CONV);
    assign out_valid = (state_q == S_HOLD);
    assign q_bcd     = q_bcd_q;
    assign r_bcd     = r_bcd_q;

endmodule
